// File: rtl/bus_activity_monitor.sv
// Bus activity monitor: synchronizes raw bus pins, declares a frame active on the
// first transition and ends it after IDLE_COUNT consecutive quiet cycles. Emits
// single-cycle start/end strobes and a saturating count of completed frames.
module bus_activity_monitor #(
    parameter int unsigned          NUM_LINES       = 4,
    parameter int unsigned          SYNC_STAGES     = 2,
    parameter logic [NUM_LINES-1:0] IDLE_LEVELS     = {NUM_LINES{1'b1}},
    parameter int unsigned          IDLE_COUNT      = 1024,
    parameter int unsigned          FRAME_CNT_WIDTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_LINES-1:0]       bus_lines,
    output logic                       comm_active,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int unsigned     CntW    = $clog2(IDLE_COUNT);
    localparam logic [CntW-1:0] CntLast = CntW'(IDLE_COUNT - 1);

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } state_e;

    // Synchronizer chain; index 0 captures the raw pins, top index is the output.
    logic [SYNC_STAGES-1:0][NUM_LINES-1:0] r_sync;
    logic [NUM_LINES-1:0]                  r_prev;
    state_e                                r_state;
    logic [CntW-1:0]                       r_cnt;
    logic                                  r_frame_start;
    logic                                  r_frame_end;
    logic [FRAME_CNT_WIDTH-1:0]            r_frame_count;

    logic [NUM_LINES-1:0] w_sync_out;
    logic                 w_edge;
    logic                 w_busy;
    logic                 w_quiet;
    state_e               w_state_d;
    logic [CntW-1:0]      w_cnt_d;
    logic                 w_start_d;
    logic                 w_end_d;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = |(w_sync_out ^ r_prev);
    // Busy catches lines parked away from idle, e.g. a chip-select held low.
    assign w_busy     = |(w_sync_out ^ IDLE_LEVELS);
    assign w_quiet    = !w_edge && !w_busy;

    // Shift pins through the synchronizer and remember the previous synced value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVELS}};
            r_prev <= IDLE_LEVELS;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus_lines};
            r_prev <= w_sync_out;
        end
    end

    // Next-state, idle counter and strobe decode.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_start_d = 1'b0;
        w_end_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (w_edge) begin
                    w_state_d = StActive;
                    w_start_d = 1'b1;
                end
            end
            StActive: begin
                if (!w_quiet) begin
                    // Activity in the expiry cycle also lands here: frame continues.
                    w_cnt_d = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_d = StIdle;
                    w_end_d   = 1'b1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // State, counter, strobes and saturating frame count registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_frame_start <= w_start_d;
            r_frame_end   <= w_end_d;
            if (w_end_d && (r_frame_count != {FRAME_CNT_WIDTH{1'b1}})) begin
                r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    assign comm_active = (r_state == StActive);
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_bus_activity_monitor.sv
// Self-checking bench for bus_activity_monitor: directed scenarios plus random
// pin traffic, all compared every cycle against a history-based reference model.
module tb_bus_activity_monitor;

    localparam int unsigned NL   = 4;
    localparam int unsigned SS   = 2;
    localparam int unsigned IC   = 8;
    localparam int unsigned FCW  = 4;
    localparam logic [NL-1:0] IDLE = 4'b1111;
    localparam int unsigned CMAX = (1 << FCW) - 1;

    logic           sys_clk;
    logic           sys_rst;
    logic [NL-1:0]  bus_lines;
    logic           comm_active;
    logic           frame_start;
    logic           frame_end;
    logic [FCW-1:0] frame_count;

    bus_activity_monitor #(
        .NUM_LINES      (NL),
        .SYNC_STAGES    (SS),
        .IDLE_LEVELS    (IDLE),
        .IDLE_COUNT     (IC),
        .FRAME_CNT_WIDTH(FCW)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bus_lines  (bus_lines),
        .comm_active(comm_active),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .frame_count(frame_count)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pin samples per edge; the synced view at edge n is the sample
    // taken SS edges earlier, and the previous view one edge before that.
    logic [NL-1:0] hist[$];
    bit            m_active;
    int            m_quiet_run;
    int            m_count;
    bit            exp_start;
    bit            exp_end;

    task automatic model_step(input logic [NL-1:0] b, input logic r);
        logic [NL-1:0] syncv;
        logic [NL-1:0] prevv;
        bit            e;
        bit            q;
        exp_start = 1'b0;
        exp_end   = 1'b0;
        if (r) begin
            hist.delete();
            for (int i = 0; i < SS + 2; i++) hist.push_back(IDLE);
            m_active    = 1'b0;
            m_quiet_run = 0;
            m_count     = 0;
        end else begin
            hist.push_front(b);
            void'(hist.pop_back());
            syncv = hist[SS];
            prevv = hist[SS+1];
            e = (syncv != prevv);
            q = !e && (syncv == IDLE);
            if (!m_active) begin
                if (e) begin
                    m_active    = 1'b1;
                    exp_start   = 1'b1;
                    m_quiet_run = 0;
                end
            end else if (!q) begin
                m_quiet_run = 0;
            end else begin
                m_quiet_run++;
                if (m_quiet_run == IC) begin
                    m_active    = 1'b0;
                    exp_end     = 1'b1;
                    m_quiet_run = 0;
                    if (m_count < CMAX) m_count++;
                end
            end
        end
    endtask

    int cyc = 0;
    int n_start = 0;
    int n_end = 0;
    int last_end_cyc = -100;
    bit b2b_en = 1'b0;
    int b2b_seen = 0;

    // Drive one cycle of inputs, step the model at the edge, compare at the negedge.
    task automatic tick(input logic [NL-1:0] b, input logic r);
        bus_lines = b;
        sys_rst   = r;
        @(posedge sys_clk);
        cyc++;
        model_step(b, r);
        @(negedge sys_clk);
        check_eq("comm_active", 32'(comm_active), 32'(m_active));
        check_eq("frame_start", 32'(frame_start), 32'(exp_start));
        check_eq("frame_end", 32'(frame_end), 32'(exp_end));
        check_eq("frame_count", 32'(frame_count), 32'(m_count));
        check_eq("start_end_excl", 32'(frame_start & frame_end), 0);
        if (frame_start === 1'b1) begin
            n_start++;
            if (b2b_en && b2b_seen > 0) check_eq("b2b_gap", 32'(cyc - last_end_cyc), 1);
            if (b2b_en) b2b_seen++;
        end
        if (frame_end === 1'b1) begin
            n_end++;
            last_end_cyc = cyc;
        end
    endtask

    int k;
    int e0;
    int s0;
    int lowcnt;
    int hold;
    logic [NL-1:0] pat;
    logic rr;

    initial begin
        for (int i = 0; i < SS + 2; i++) hist.push_back(IDLE);
        bus_lines = IDLE;
        sys_rst   = 1'b1;

        // 1. Reset held three cycles, then 20 idle cycles without strobes.
        repeat (3) tick(IDLE, 1'b1);
        check_eq("rst_active", 32'(comm_active), 0);
        check_eq("rst_start", 32'(frame_start), 0);
        check_eq("rst_end", 32'(frame_end), 0);
        check_eq("rst_count", 32'(frame_count), 0);
        s0 = n_start; e0 = n_end;
        repeat (20) tick(IDLE, 1'b0);
        check_eq("rst_no_strobes", 32'((n_start - s0) + (n_end - e0)), 0);

        // 2. Single frame: line 0 low at edge k, high again at k+3.
        k = cyc + 1; e0 = n_end;
        repeat (3) tick(4'b1110, 1'b0);
        check_eq("t2_start", 32'(frame_start), 1);
        check_eq("t2_active", 32'(comm_active), 1);
        repeat (10) tick(IDLE, 1'b0);
        check_eq("t2_no_early_end", 32'(n_end - e0), 0);
        check_eq("t2_still_active", 32'(comm_active), 1);
        tick(IDLE, 1'b0);
        check_eq("t2_end", 32'(frame_end), 1);
        check_eq("t2_fall", 32'(comm_active), 0);
        check_eq("t2_end_cycle", 32'(last_end_cyc), 32'(k + 13));
        check_eq("t2_count", 32'(frame_count), 1);

        // 3. Line 3 held low for 50 cycles, then released.
        k = cyc + 1; e0 = n_end; lowcnt = 0;
        for (int j = 0; j < 50; j++) begin
            tick(4'b0111, 1'b0);
            if (j >= 2 && comm_active !== 1'b1) lowcnt++;
        end
        k = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            tick(IDLE, 1'b0);
            if (comm_active !== 1'b1) lowcnt++;
        end
        check_eq("t3_active_throughout", 32'(lowcnt), 0);
        tick(IDLE, 1'b0);
        check_eq("t3_end", 32'(frame_end), 1);
        check_eq("t3_end_cycle", 32'(last_end_cyc), 32'(k + 10));
        repeat (5) tick(IDLE, 1'b0);
        check_eq("t3_one_end", 32'(n_end - e0), 1);
        check_eq("t3_count", 32'(frame_count), 2);

        // 4. Edge registered exactly in the expiry cycle keeps the frame alive.
        k = cyc + 1; e0 = n_end; lowcnt = 0;
        tick(4'b1110, 1'b0);
        repeat (8) tick(IDLE, 1'b0);
        tick(4'b1101, 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick(IDLE, 1'b0);
            if (comm_active !== 1'b1) lowcnt++;
        end
        check_eq("t4_no_end", 32'(n_end - e0), 0);
        check_eq("t4_stays_active", 32'(lowcnt), 0);
        tick(IDLE, 1'b0);
        check_eq("t4_late_end", 32'(frame_end), 1);
        check_eq("t4_end_cycle", 32'(last_end_cyc), 32'(k + 20));

        // 5. Seventeen back-to-back frames from a clean reset; count saturates at 15.
        repeat (2) tick(IDLE, 1'b1);
        pat = IDLE;
        pat[$urandom_range(0, NL - 1)] = 1'b0;
        s0 = n_start; e0 = n_end;
        b2b_en = 1'b1; b2b_seen = 0;
        for (int f = 0; f < 17; f++) begin
            tick(pat, 1'b0);
            repeat (9) tick(IDLE, 1'b0);
        end
        repeat (12) tick(IDLE, 1'b0);
        b2b_en = 1'b0;
        check_eq("t5_starts", 32'(n_start - s0), 17);
        check_eq("t5_ends", 32'(n_end - e0), 17);
        check_eq("t5_saturated", 32'(frame_count), 15);

        // 6. Reset in the middle of a frame.
        tick(4'b1011, 1'b0);
        repeat (3) tick(IDLE, 1'b0);
        check_eq("t6_pre_active", 32'(comm_active), 1);
        e0 = n_end;
        tick(IDLE, 1'b1);
        check_eq("t6_active", 32'(comm_active), 0);
        check_eq("t6_end", 32'(frame_end), 0);
        check_eq("t6_count", 32'(frame_count), 0);
        repeat (20) tick(IDLE, 1'b0);
        check_eq("t6_no_end", 32'(n_end - e0), 0);
        check_eq("t6_count_after", 32'(frame_count), 0);

        // 7. Random pin traffic with occasional resets, checked by the model.
        for (int i = 0; i < 200; i++) begin
            rr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) == 0) begin
                pat  = IDLE;
                hold = $urandom_range(1, 20);
            end else begin
                pat  = NL'($urandom);
                hold = $urandom_range(1, 6);
            end
            tick(pat, rr);
            repeat (hold - 1) tick(pat, 1'b0);
        end
        repeat (12) tick(IDLE, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
